// File: rtl/button_debouncer_pkg.sv
// Shared constants for the push-button conditioning block: channel indices and default timing.
package button_debouncer_pkg;

    localparam int NUM_BTN      = 6;
    localparam int BTN_UP       = 0;
    localparam int BTN_DOWN     = 1;
    localparam int BTN_LEFT     = 2;
    localparam int BTN_RIGHT    = 3;
    localparam int BTN_CENTER   = 4;
    localparam int BTN_RESET    = 5;

    localparam int STABLE_COUNT_DEF  = 1000000;
    localparam int CNT_WIDTH_DEF     = 20;
    localparam int REPEAT_DELAY_DEF  = 50000000;
    localparam int REPEAT_PERIOD_DEF = 15000000;

    // Only the four direction channels auto-repeat.
    localparam logic [NUM_BTN-1:0] REPEAT_MASK_DEF =
        (NUM_BTN'(1) << BTN_UP) | (NUM_BTN'(1) << BTN_DOWN) |
        (NUM_BTN'(1) << BTN_LEFT) | (NUM_BTN'(1) << BTN_RIGHT);

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle between the board pins and the debouncer; master drives raw, slave returns level/pulse.
interface button_debouncer_if #(
    parameter int NUM_BTN = button_debouncer_pkg::NUM_BTN
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;

    modport master (output btn_raw, input btn_level, input btn_pulse);
    modport slave  (input btn_raw, output btn_level, output btn_pulse);
endinterface

// File: rtl/button_debouncer_channel.sv
// One button: two-flop synchronizer, stability counter, registered level and press pulse.
// With AUTO_REPEAT_EN defined, a held channel (REPEAT_ON) re-pulses after REPEAT_DELAY, then every REPEAT_PERIOD.
module button_debouncer_channel
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_COUNT  = STABLE_COUNT_DEF,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter bit REPEAT_ON     = 1'b0
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse
);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_level;
    logic                 r_pulse;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_level_nxt;
    logic                 w_press;
    logic                 w_pulse_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    // Stability decision: a differing level is accepted on its STABLE_COUNT-th consecutive cycle.
    always_comb begin
        w_cnt_nxt   = '0;
        w_level_nxt = r_level;
        w_press     = 1'b0;
        if (r_sync2 == r_level) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != CNT_WIDTH'(STABLE_COUNT - 1)) begin
            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end else begin
            w_level_nxt = r_sync2;
            w_press     = r_sync2;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rpt;
    logic             r_first;
    logic [RPT_W-1:0] w_rpt_nxt;
    logic             w_first_nxt;
    logic             w_rpt_fire;
    logic [RPT_W-1:0] w_rpt_last;

    // Repeat timer: runs only while the accepted level stays high; first interval is the long delay.
    always_comb begin
        w_rpt_nxt   = '0;
        w_first_nxt = 1'b1;
        w_rpt_fire  = 1'b0;
        w_rpt_last  = r_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
        if (REPEAT_ON && r_level && w_level_nxt) begin
            if (r_rpt == w_rpt_last) begin
                w_rpt_fire  = 1'b1;
                w_rpt_nxt   = '0;
                w_first_nxt = 1'b0;
            end else begin
                w_rpt_nxt   = r_rpt + RPT_W'(1);
                w_first_nxt = r_first;
            end
        end else begin
            w_rpt_nxt   = '0;
            w_first_nxt = 1'b1;
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rpt   <= '0;
            r_first <= 1'b1;
        end else begin
            r_rpt   <= w_rpt_nxt;
            r_first <= w_first_nxt;
        end
    end

    assign w_pulse_nxt = w_press | w_rpt_fire;
`else
    assign w_pulse_nxt = w_press;
`endif

    // Synchronizer, counter, level and pulse registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BTN raw push-buttons into clean levels and one-cycle press pulses.
// Optional AUTO_REPEAT_EN adds held-button auto-repeat on the REPEAT_MASK channels.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int NUM_BTN       = button_debouncer_pkg::NUM_BTN,
    parameter int STABLE_COUNT  = STABLE_COUNT_DEF,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK = REPEAT_MASK_DEF
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    button_debouncer_if.slave         bus
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_pulse;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        button_debouncer_channel #(
            .STABLE_COUNT  (STABLE_COUNT),
            .CNT_WIDTH     (CNT_WIDTH)
`ifdef AUTO_REPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_ON     (REPEAT_MASK[g])
`endif
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .i_raw   (bus.btn_raw[g]),
            .o_level (w_level[g]),
            .o_pulse (w_pulse[g])
        );
    end

    assign bus.btn_level = w_level;
    assign bus.btn_pulse = w_pulse;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: windowed reference model feeds a queue, a negedge monitor compares.
module tb_button_debouncer;

    localparam int NB = 6;
    localparam int S  = 4;
    localparam int CW = 3;
`ifdef AUTO_REPEAT_EN
    localparam int RD = 8;
    localparam int RP = 3;
    localparam logic [NB-1:0] RMASK = 6'b001111;
`endif

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    button_debouncer_if #(.NUM_BTN(NB)) bus ();

    button_debouncer #(
        .NUM_BTN       (NB),
        .STABLE_COUNT  (S),
        .CNT_WIDTH     (CW)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .REPEAT_MASK   (RMASK)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] pls;
    } exp_t;

    exp_t q[$];

    // Reference model: a level flips once the synchronized input has disagreed with it
    // for the last S edges, all of them after the previous flip/reset.
    bit [NB-1:0] m_s1, m_s2, m_lvl, m_pls;
    bit [NB-1:0] m_hist [int];
    int          m_last [NB];
    int          m_press[NB];
    int          m_edge = 0;
    bit          m_ok;
    int          m_d;
    exp_t        m_e;

    always @(posedge clk) begin
        m_edge++;
        m_pls = '0;
        if (reset) begin
            m_s1  = '0;
            m_s2  = '0;
            m_lvl = '0;
            for (int ch = 0; ch < NB; ch++) m_last[ch] = m_edge;
        end else begin
            m_hist[m_edge] = m_s2;
            for (int ch = 0; ch < NB; ch++) begin
                m_ok = (m_edge - m_last[ch]) >= S;
                for (int k = 0; k < S; k++)
                    if (m_ok && m_hist[m_edge - k][ch] == m_lvl[ch]) m_ok = 1'b0;
                if (m_ok) begin
                    m_lvl[ch]  = ~m_lvl[ch];
                    m_last[ch] = m_edge;
                    m_pls[ch]  = m_lvl[ch];
                    if (m_lvl[ch]) m_press[ch] = m_edge;
                end
`ifdef AUTO_REPEAT_EN
                else if (m_lvl[ch] && RMASK[ch]) begin
                    m_d = m_edge - m_press[ch];
                    if (m_d >= RD && ((m_d - RD) % RP) == 0) m_pls[ch] = 1'b1;
                end
`endif
            end
            m_s2 = m_s1;
            m_s1 = bus.btn_raw;
        end
        m_e.lvl = m_lvl;
        m_e.pls = m_pls;
        q.push_back(m_e);
    end

    task automatic check(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at t=%0t: got %b expected %b", nm, $time, act, exp);
    endtask

    // Monitor: every edge presents a new level/pulse word.
    exp_t mon_e;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("btn_level", bus.btn_level, mon_e.lvl);
            check("btn_pulse", bus.btn_pulse, mon_e.pls);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int          k_edge;
    int          at_edge;
    bit          seen;
    logic [NB-1:0] r;

    initial begin
        reset       = 1'b1;
        bus.btn_raw = 6'b111111;
        tick(3);
        reset = 1'b0;
        tick(8);
        bus.btn_raw = 6'b000000;
        tick(8);

        // Clean press on center with explicit latency measurement.
        bus.btn_raw = 6'b010000;
        k_edge = cyc + 1;
        seen = 1'b0;
        at_edge = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.btn_level[4]) begin
                seen = 1'b1;
                at_edge = cyc;
            end
        end
        n_chk++;
        if (seen && at_edge == k_edge + 1 + S) n_pass++;
        else $display("FAIL latency_center: level rose at edge %0d expected %0d (seen=%0d)", at_edge, k_edge + 1 + S, seen);
        tick(4);
        bus.btn_raw = 6'b000000;
        tick(8);

        // Bounce on up, then hold.
        for (int i = 0; i < 4; i++) begin
            bus.btn_raw = (i % 2 == 0) ? 6'b000001 : 6'b000000;
            tick();
        end
        bus.btn_raw = 6'b000001;
        tick(10);
        bus.btn_raw = 6'b000000;
        tick(10);

        // Simultaneous left/right, then reset in the middle of a down count.
        bus.btn_raw = 6'b001100;
        tick(8);
        bus.btn_raw = 6'b001110;
        tick(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(10);
        bus.btn_raw = 6'b000000;
        tick(8);

`ifdef AUTO_REPEAT_EN
        bus.btn_raw = 6'b010010;
        tick(30);
        bus.btn_raw = 6'b000000;
        tick(10);
`endif

        // Randomized: sparse flips produce clean presses and occasional bounces, plus rare resets.
        for (int i = 0; i < 1500; i++) begin
            r = bus.btn_raw;
            if ($urandom_range(0, 7) == 0) begin
                k_edge = $urandom_range(0, NB - 1);
                r[k_edge] = ~r[k_edge];
            end
            bus.btn_raw = r;
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        tick(2);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
